mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/arb_id_fifo.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
`ifndef XLEN
`define XLEN 32
`endif

package mem_arb_pkg;

    // Owner of a bus transaction; stored in the in-order tracker.
    typedef enum logic {
        ARB_ID_FETCH = 1'b0,
        ARB_ID_DATA  = 1'b1
    } arb_id_e;

    localparam int ARB_NUM_REQ = 2;
    localparam int ARB_XLEN    = `XLEN;

endpackage

// File: rtl/arb_id_fifo.sv
// rtl/arb_id_fifo.sv - in-order owner-ID tracker (DEPTH x 1-bit sync FIFO)
//
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   push, wr_id     enqueue owner ID (ignored when full)
//   pop             dequeue head (ignored when empty)
//   rd_id           head-of-queue owner ID
//   full, empty     occupancy flags
`ifndef XLEN
`define XLEN 32
`endif

module arb_id_fifo
    import mem_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic    clk,
    input  logic    rst_b,
    input  logic    push,
    input  arb_id_e wr_id,
    input  logic    pop,
    output arb_id_e rd_id,
    output logic    full,
    output logic    empty
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_id   = arb_id_e'(mem[rd_ptr]);

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one SRAM-like bus between fetch and data ports
//
// Ports:
//   clk, rst_b                 clock, asynchronous active-low reset
//   iram_*                     fetch request/response port (read only)
//   dram_*                     data request/response port (read/write)
//   bus_*                      shared memory bus towards the bridge
// Grants one address-phase request per cycle, records each accepted owner in
// an in-order tracker and routes bus_data_ok back to that owner.
// Build option: MEM_PORT_ARB_RR_EN selects round-robin arbitration between
// simultaneous requests; otherwise data has fixed priority over fetch.
`ifndef XLEN
`define XLEN 32
`endif

module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 iram_req,
    input  logic [`XLEN-1:0]     iram_addr,
    output logic                 iram_addr_ok,
    output logic                 iram_data_ok,
    output logic [`XLEN-1:0]     iram_rdata,
    input  logic                 dram_req,
    input  logic                 dram_write,
    input  logic [`XLEN/8-1:0]   dram_wstrb,
    input  logic [`XLEN-1:0]     dram_addr,
    input  logic [`XLEN-1:0]     dram_wdata,
    output logic                 dram_addr_ok,
    output logic                 dram_data_ok,
    output logic [`XLEN-1:0]     dram_rdata,
    output logic                 bus_req,
    output logic                 bus_write,
    output logic [`XLEN/8-1:0]   bus_wstrb,
    output logic [`XLEN-1:0]     bus_addr,
    output logic [`XLEN-1:0]     bus_wdata,
    input  logic                 bus_addr_ok,
    input  logic                 bus_data_ok,
    input  logic [`XLEN-1:0]     bus_rdata
);

    import mem_arb_pkg::*;

    logic [ARB_NUM_REQ-1:0] req_vec;
    logic                   any_req;
    logic                   lock_valid;
    arb_id_e                lock_id;
    logic                   lock_hold;
    arb_id_e                sel_id;
    arb_id_e                head_id;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   accept;
    logic                   resp_pop;

    assign req_vec = {dram_req, iram_req};
    assign any_req = |req_vec;

    // A lock only holds while its owner keeps requesting; a flushed EX
    // request releases the bus to fetch in the very same cycle.
    assign lock_hold = lock_valid &&
                       ((lock_id == ARB_ID_DATA) ? dram_req : iram_req);

`ifdef MEM_PORT_ARB_RR_EN
    arb_id_e last_id;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            last_id <= ARB_ID_DATA;
        end else if (accept) begin
            last_id <= sel_id;
        end
    end
`endif

    always_comb begin
        sel_id = ARB_ID_FETCH;
        if (lock_hold) begin
            sel_id = lock_id;
        end else if (dram_req && iram_req) begin
`ifdef MEM_PORT_ARB_RR_EN
            sel_id = (last_id == ARB_ID_DATA) ? ARB_ID_FETCH : ARB_ID_DATA;
`else
            sel_id = ARB_ID_DATA;
`endif
        end else if (dram_req) begin
            sel_id = ARB_ID_DATA;
        end
    end

    // Full blocks new requests even when a response pops this cycle, which
    // keeps addr_ok independent of data_ok.
    assign bus_req = rst_b && any_req && !fifo_full;
    assign accept  = bus_req && bus_addr_ok;

    assign iram_addr_ok = accept && (sel_id == ARB_ID_FETCH);
    assign dram_addr_ok = accept && (sel_id == ARB_ID_DATA);

    always_comb begin
        bus_write = 1'b0;
        bus_wstrb = '0;
        bus_addr  = iram_addr;
        bus_wdata = '0;
        if (sel_id == ARB_ID_DATA) begin
            bus_write = dram_write;
            bus_wstrb = dram_wstrb;
            bus_addr  = dram_addr;
            bus_wdata = dram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lock_valid <= 1'b0;
            lock_id    <= ARB_ID_DATA;
        end else if (accept) begin
            lock_valid <= 1'b0;
        end else if (bus_req) begin
            lock_valid <= 1'b1;
            lock_id    <= sel_id;
        end else if (!lock_hold) begin
            lock_valid <= 1'b0;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (accept),
        .wr_id (sel_id),
        .pop   (resp_pop),
        .rd_id (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Stray responses with nothing outstanding are dropped.
    assign resp_pop     = rst_b && bus_data_ok && !fifo_empty;
    assign iram_data_ok = resp_pop && (head_id == ARB_ID_FETCH);
    assign dram_data_ok = resp_pop && (head_id == ARB_ID_DATA);
    assign iram_rdata   = bus_rdata;
    assign dram_rdata   = bus_rdata;

    a_resp_has_owner: assert property (@(posedge clk) disable iff (!rst_b)
        !(bus_data_ok && fifo_empty))
        else $warning("mem_port_arbiter: bus_data_ok with no outstanding request");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_port_arbiter;

    logic                 clk = 1'b0;
    logic                 rst_b;
    logic                 iram_req;
    logic [`XLEN-1:0]     iram_addr;
    logic                 iram_addr_ok;
    logic                 iram_data_ok;
    logic [`XLEN-1:0]     iram_rdata;
    logic                 dram_req;
    logic                 dram_write;
    logic [`XLEN/8-1:0]   dram_wstrb;
    logic [`XLEN-1:0]     dram_addr;
    logic [`XLEN-1:0]     dram_wdata;
    logic                 dram_addr_ok;
    logic                 dram_data_ok;
    logic [`XLEN-1:0]     dram_rdata;
    logic                 bus_req;
    logic                 bus_write;
    logic [`XLEN/8-1:0]   bus_wstrb;
    logic [`XLEN-1:0]     bus_addr;
    logic [`XLEN-1:0]     bus_wdata;
    logic                 bus_addr_ok;
    logic                 bus_data_ok;
    logic [`XLEN-1:0]     bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .iram_req     (iram_req),
        .iram_addr    (iram_addr),
        .iram_addr_ok (iram_addr_ok),
        .iram_data_ok (iram_data_ok),
        .iram_rdata   (iram_rdata),
        .dram_req     (dram_req),
        .dram_write   (dram_write),
        .dram_wstrb   (dram_wstrb),
        .dram_addr    (dram_addr),
        .dram_wdata   (dram_wdata),
        .dram_addr_ok (dram_addr_ok),
        .dram_data_ok (dram_data_ok),
        .dram_rdata   (dram_rdata),
        .bus_req      (bus_req),
        .bus_write    (bus_write),
        .bus_wstrb    (bus_wstrb),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // owner: 0 fetch, 1 data, 2 no bus request expected
    task automatic grant(input string tag, input int owner, input logic aok,
                         input logic [31:0] addr);
        bus_addr_ok = aok;
        @(negedge clk);
        chk({tag, "_iok"}, iram_addr_ok, (owner == 0) && aok);
        chk({tag, "_dok"}, dram_addr_ok, (owner == 1) && aok);
        chk({tag, "_req"}, bus_req, owner != 2);
        if (owner != 2) begin
            chk({tag, "_addr"}, bus_addr, addr);
            chk({tag, "_wr"}, bus_write, (owner == 1) ? dram_write : 1'b0);
            chk({tag, "_strb"}, bus_wstrb, (owner == 1) ? dram_wstrb : '0);
            chk({tag, "_wd"}, bus_wdata, (owner == 1) ? dram_wdata : '0);
        end
        if (owner != 2 && aok) exp_q.push_back(owner);
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
    endtask

    task automatic resp(input string tag, input logic [31:0] val);
        int o;
        bus_data_ok = 1'b1;
        bus_rdata   = val;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            o = exp_q.pop_front();
            chk({tag, "_idok"}, iram_data_ok, o == 0);
            chk({tag, "_ddok"}, dram_data_ok, o == 1);
            chk({tag, "_rdi"}, iram_rdata, val);
            chk({tag, "_rdd"}, dram_rdata, val);
        end else begin
            chk({tag, "_drop_i"}, iram_data_ok, 1'b0);
            chk({tag, "_drop_d"}, dram_data_ok, 1'b0);
        end
        @(posedge clk); #1;
        bus_data_ok = 1'b0;
    endtask

    task automatic idle_inputs();
        iram_req = 0; iram_addr = '0; dram_req = 0; dram_write = 0;
        dram_wstrb = '0; dram_addr = '0; dram_wdata = '0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    endtask

    initial begin
        int first;
        int o;
        // Reset with all inputs active: outputs must stay quiet
        idle_inputs();
        rst_b = 1'b0;
        iram_req = 1; dram_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
        @(negedge clk);
        chk("rst_req", bus_req, 0);
        chk("rst_iok", iram_addr_ok, 0);
        chk("rst_dok", dram_addr_ok, 0);
        chk("rst_idok", iram_data_ok, 0);
        chk("rst_ddok", dram_data_ok, 0);
        chk("rst_cnt", dut.u_id_fifo.count, 0);
        @(posedge clk); #1;
        idle_inputs();
        rst_b = 1'b1;
        grant("idle", 2, 1'b0, 0);

        // 1: single data write and its ack
        dram_req = 1; dram_write = 1; dram_addr = 32'h100; dram_wstrb = 4'b0011;
        dram_wdata = 32'hDEAD_BEEF;
        grant("t1", 1, 1'b1, 32'h100);
        idle_inputs();
        @(negedge clk);
        chk("t1_cnt1", dut.u_id_fifo.count, 1);
        @(posedge clk); #1;
        resp("t1r", 32'h11);
        @(negedge clk);
        chk("t1_cnt0", dut.u_id_fifo.count, 0);
        @(posedge clk); #1;

        // 2: simultaneous requests
`ifdef MEM_PORT_ARB_RR_EN
        first = 0;
`else
        first = 1;
`endif
        iram_req = 1; iram_addr = 32'h1000;
        dram_req = 1; dram_addr = 32'h2000; dram_wdata = 32'h55;
        grant("t2a", first, 1'b1, (first == 0) ? 32'h1000 : 32'h2000);
        if (first == 0) iram_req = 0; else dram_req = 0;
        grant("t2b", 1 - first, 1'b1, (first == 0) ? 32'h2000 : 32'h1000);
        idle_inputs();
        resp("t2r0", 32'hA0);
        resp("t2r1", 32'hA1);

        // 3: stalled fetch holds the bus while data arrives
        iram_req = 1; iram_addr = 32'h200;
        grant("t3c1", 0, 1'b0, 32'h200);
        dram_req = 1; dram_addr = 32'h300; dram_write = 1; dram_wstrb = 4'hF;
        dram_wdata = 32'h3333;
        grant("t3c2", 0, 1'b0, 32'h200);
        grant("t3c3", 0, 1'b0, 32'h200);
        grant("t3acc", 0, 1'b1, 32'h200);
        iram_req = 0;
        grant("t3d", 1, 1'b1, 32'h300);
        idle_inputs();
        resp("t3r0", 32'hB0);
        resp("t3r1", 32'hB1);

        // 4: data lock released by flush, fetch takes the same cycle
        dram_req = 1; dram_addr = 32'h400;
        grant("t4lk", 1, 1'b0, 32'h400);
        dram_req = 0; iram_req = 1; iram_addr = 32'h500;
        grant("t4f", 0, 1'b1, 32'h500);
        idle_inputs();
        resp("t4r", 32'hC4);
        @(negedge clk);
        chk("t4_cnt", dut.u_id_fifo.count, 0);
        @(posedge clk); #1;

        // 5: tracker full blocks even with a same-cycle pop
        iram_req = 1; iram_addr = 32'h600;
        grant("t5a", 0, 1'b1, 32'h600);
        grant("t5b", 0, 1'b1, 32'h600);
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hC0;
        @(negedge clk);
        chk("t5_full_req", bus_req, 0);
        chk("t5_full_iok", iram_addr_ok, 0);
        o = exp_q.pop_front();
        chk("t5_pop_idok", iram_data_ok, o == 0);
        chk("t5_pop_ddok", dram_data_ok, o == 1);
        @(posedge clk); #1;
        bus_data_ok = 0;
        grant("t5c", 0, 1'b1, 32'h600);
        idle_inputs();
        resp("t5r1", 32'hC1);
        resp("t5r2", 32'hC2);
        resp("t5stray", 32'hCF);
        @(negedge clk);
        chk("t5_cnt", dut.u_id_fifo.count, 0);
        @(posedge clk); #1;

        // 6: asynchronous reset with two outstanding
        iram_req = 1; iram_addr = 32'h700;
        grant("t6a", 0, 1'b1, 32'h700);
        grant("t6b", 0, 1'b1, 32'h700);
        @(negedge clk);
        chk("t6_cnt2", dut.u_id_fifo.count, 2);
        #2;
        rst_b = 1'b0;
        dram_req = 1; bus_addr_ok = 1;
        #1;
        chk("t6_cnt_clr", dut.u_id_fifo.count, 0);
        chk("t6_rst_req", bus_req, 0);
        chk("t6_rst_iok", iram_addr_ok, 0);
        chk("t6_rst_dok", dram_addr_ok, 0);
        exp_q.delete();
        @(posedge clk); #1;
        idle_inputs();
        rst_b = 1'b1;
        resp("t6stray", 32'hE0);
        @(negedge clk);
        chk("t6_cnt_end", dut.u_id_fifo.count, 0);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
